// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. Port 0 (CPU) has
// fixed priority; port 1 (debug/DMA) is forced in after MAX_WAIT consecutive port-0 wins.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among valid requests
// ACCESS | granted port sees Ready; memory strobe held for the whole cycle
// RESP   | granted port sees RValid; memory strobes low
module data_mem_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int DEPTH    = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0Valid,
    input  logic        req0Write,
    input  logic [31:0] req0Addr,
    input  logic [31:0] req0WData,
    output logic        req0Ready,
    output logic        req0RValid,
    output logic [31:0] req0RData,
    input  logic        req1Valid,
    input  logic        req1Write,
    input  logic [31:0] req1Addr,
    input  logic [31:0] req1WData,
    output logic        req1Ready,
    output logic        req1RValid,
    output logic [31:0] req1RData,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q;
    logic [WCW-1:0]  wait_cnt_q;
    logic            gnt1_q;
    logic            wr_q;
    logic            ready0_q, ready1_q;
    logic            rvalid0_q, rvalid1_q;
    logic [31:0]     rdata0_q, rdata1_q;
    logic [31:0]     mem_addr_q, mem_wdata_q;
    logic            mem_write_q, mem_read_q;

    logic            gnt1_d;
    logic            sel_write_d;
    logic [31:0]     sel_addr_d;
    logic [31:0]     sel_wdata_d;
    logic            in_range_d;
    logic [WCW-1:0]  wait_cnt_d;

    always_comb begin
        gnt1_d      = req1Valid && (!req0Valid || (wait_cnt_q >= WAIT_LIM));
        sel_write_d = gnt1_d ? req1Write : req0Write;
        sel_addr_d  = gnt1_d ? req1Addr  : req0Addr;
        sel_wdata_d = gnt1_d ? req1WData : req0WData;
        in_range_d  = sel_addr_d < 32'(DEPTH);
        // Only consulted when a grant is actually made in IDLE.
        if (gnt1_d || !req1Valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            gnt1_q      <= 1'b0;
            wr_q        <= 1'b0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0Valid || req1Valid) begin
                        gnt1_q      <= gnt1_d;
                        wr_q        <= sel_write_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_write_q <= sel_write_d && in_range_d;
                        mem_read_q  <= !sel_write_d && in_range_d;
                        ready0_q    <= !gnt1_d;
                        ready1_q    <= gnt1_d;
                        wait_cnt_q  <= wait_cnt_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready0_q    <= 1'b0;
                    ready1_q    <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    // An out-of-range read never raised memRead and returns zero.
                    if (gnt1_q) begin
                        rvalid1_q <= 1'b1;
                        if (!wr_q) rdata1_q <= mem_read_q ? memReadData : '0;
                    end else begin
                        rvalid0_q <= 1'b1;
                        if (!wr_q) rdata0_q <= mem_read_q ? memReadData : '0;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0Ready    = ready0_q;
    assign req1Ready    = ready1_q;
    assign req0RValid   = rvalid0_q;
    assign req1RValid   = rvalid1_q;
    assign req0RData    = rdata0_q;
    assign req1RData    = rdata1_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign memWrite     = mem_write_q;
    assign memRead      = mem_read_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: latency, arbitration fairness, range checks,
// back-to-back throughput and asynchronous abort, against a falling-edge memory model.
module tb_data_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0Valid = 1'b0, req0Write = 1'b0;
    logic [31:0] req0Addr = '0, req0WData = '0;
    logic        req1Valid = 1'b0, req1Write = 1'b0;
    logic [31:0] req1Addr = '0, req1WData = '0;
    logic        req0Ready, req0RValid, req1Ready, req1RValid;
    logic [31:0] req0RData, req1RData;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite, memRead;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.MAX_WAIT(3), .DEPTH(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0Valid(req0Valid), .req0Write(req0Write), .req0Addr(req0Addr),
        .req0WData(req0WData), .req0Ready(req0Ready), .req0RValid(req0RValid),
        .req0RData(req0RData),
        .req1Valid(req1Valid), .req1Write(req1Write), .req1Addr(req1Addr),
        .req1WData(req1WData), .req1Ready(req1Ready), .req1RValid(req1RValid),
        .req1RData(req1RData),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [32];
    always @(negedge Clk) if (memWrite && memAddress < 32) mem[memAddress[4:0]] <= memWriteData;
    always_comb memReadData = (memAddress < 32) ? mem[memAddress[4:0]] : 32'h0;

    int strobe_cnt = 0;
    bit both_seen = 1'b0;
    always @(negedge Clk) begin
        if (memRead || memWrite) strobe_cnt++;
        if (memRead && memWrite) both_seen = 1'b1;
    end

    task automatic drive(input int p, input bit v, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0Valid = v; req0Write = w; req0Addr = a; req0WData = d;
        end else begin
            req1Valid = v; req1Write = w; req1Addr = a; req1WData = d;
        end
    endtask

    // Issues one request from an idle bus; returns the negedge index of Ready and RValid.
    task automatic transact(input int p, input bit w, input logic [31:0] a,
                            input logic [31:0] d, output int rdy_n, output int rv_n,
                            output logic [31:0] rd);
        rdy_n = -1; rv_n = -1; rd = '0;
        @(posedge Clk); #1;
        drive(p, 1'b1, w, a, d);
        for (int n = 1; n <= 12; n++) begin
            @(negedge Clk);
            if (rv_n < 0 && ((p == 0) ? req0RValid : req1RValid)) begin
                rv_n = n;
                rd = (p == 0) ? req0RData : req1RData;
                break;
            end
            if (rdy_n < 0 && ((p == 0) ? req0Ready : req1Ready)) begin
                rdy_n = n;
                @(posedge Clk); #1;
                drive(p, 1'b0, 1'b0, '0, '0);
            end
        end
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        #3 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({req0Ready, req1Ready, req0RValid, req1RValid, memRead, memWrite} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                {req0Ready, req1Ready, req0RValid, req1RValid, memRead, memWrite});
        end
        checks++;
        if (req0RData !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", req0RData); end
        checks++;
        if (req1RData !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", req1RData); end
        checks++;
        if (memAddress !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h expected 0", memAddress); end
        checks++;
        if (memWriteData !== 32'h0) begin errors++; $display("FAIL reset_memwdata: got %h expected 0", memWriteData); end
        #1 Reset = 1'b1;
    endtask

    task automatic test_write_read();
        int r, v; logic [31:0] rd;
        transact(0, 1'b1, 32'd5, 32'hDEADBEEF, r, v, rd);
        checks++;
        if (r !== 2) begin errors++; $display("FAIL wr0_ready_lat: got %0d expected 2", r); end
        checks++;
        if (v !== 3) begin errors++; $display("FAIL wr0_rvalid_lat: got %0d expected 3", v); end
        transact(0, 1'b0, 32'd5, 32'h0, r, v, rd);
        checks++;
        if (r !== 2 || v !== 3) begin errors++; $display("FAIL rd0_lat: got %0d/%0d expected 2/3", r, v); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_data: got %h expected deadbeef", rd); end
        transact(1, 1'b1, 32'd8, 32'h12345678, r, v, rd);
        checks++;
        if (v !== 3) begin errors++; $display("FAIL wr1_rvalid_lat: got %0d expected 3", v); end
        transact(1, 1'b0, 32'd8, 32'h0, r, v, rd);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL rd1_data: got %h expected 12345678", rd); end
        checks++;
        if (req0RData !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata0_hold: got %h expected deadbeef", req0RData); end
    endtask

    task automatic test_out_of_range();
        int r, v, s0; logic [31:0] rd;
        s0 = strobe_cnt;
        transact(1, 1'b0, 32'd40, 32'h0, r, v, rd);
        checks++;
        if (v !== 3) begin errors++; $display("FAIL oor_rd_rvalid: got %0d expected 3", v); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
        transact(1, 1'b1, 32'd40, 32'hBAD0BAD0, r, v, rd);
        checks++;
        if (strobe_cnt !== s0) begin errors++; $display("FAIL oor_strobes: got %0d expected %0d", strobe_cnt, s0); end
        checks++;
        if (v !== 3) begin errors++; $display("FAIL oor_wr_rvalid: got %0d expected 3", v); end
        transact(0, 1'b0, 32'd8, 32'h0, r, v, rd);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL oor_addr8_intact: got %h expected 12345678", rd); end
    endtask

    task automatic test_arbitration();
        int order[8];
        int exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int n = 0;
        @(posedge Clk); #1;
        drive(0, 1'b1, 1'b1, 32'd10, 32'hAAAA0000);
        drive(1, 1'b1, 1'b1, 32'd11, 32'hBBBB1111);
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            @(negedge Clk);
            if (req0Ready) begin order[n] = 0; n++; end
            else if (req1Ready) begin order[n] = 1; n++; end
        end
        @(posedge Clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge Clk);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL arb_grant_count: got %0d expected 8", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
            end
        end
        checks++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe_exclusive: got both=1 expected 0"); end
        checks++;
        if (mem[10] !== 32'hAAAA0000 || mem[11] !== 32'hBBBB1111) begin
            errors++; $display("FAIL arb_writes: got %h/%h expected aaaa0000/bbbb1111", mem[10], mem[11]);
        end
    endtask

    task automatic test_back_to_back();
        int rv_at[4];
        int order[4];
        int n = 0;
        @(posedge Clk); #1;
        drive(1, 1'b1, 1'b0, 32'd8, 32'h0);
        for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
            @(negedge Clk);
            if (req1RValid) begin
                rv_at[n] = cyc; n++;
                checks++;
                if (req1RData !== 32'h12345678) begin
                    errors++; $display("FAIL b2b_data: got %h expected 12345678", req1RData);
                end
            end
        end
        @(posedge Clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
        checks++;
        if (rv_at[0] !== 3) begin errors++; $display("FAIL b2b_first: got %0d expected 3", rv_at[0]); end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (rv_at[i] - rv_at[i-1] !== 3) begin
                errors++; $display("FAIL b2b_period[%0d]: got %0d expected 3", i, rv_at[i] - rv_at[i-1]);
            end
        end
        // A zero wait count shows up as three port-0 wins before port 1 is forced.
        n = 0;
        @(posedge Clk); #1;
        drive(0, 1'b1, 1'b1, 32'd12, 32'h0C0C0C0C);
        drive(1, 1'b1, 1'b1, 32'd13, 32'h0D0D0D0D);
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge Clk);
            if (req0Ready) begin order[n] = 0; n++; end
            else if (req1Ready) begin order[n] = 1; n++; end
        end
        @(posedge Clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge Clk);
        checks++;
        if (n !== 4 || order[0] !== 0 || order[1] !== 0 || order[2] !== 0 || order[3] !== 1) begin
            errors++; $display("FAIL b2b_waitcnt_zero: got n=%0d order %0d%0d%0d%0d expected 0001",
                n, order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_reset_abort();
        int r, v; logic [31:0] rd;
        bit rv_seen = 1'b0;
        transact(0, 1'b1, 32'd3, 32'h11, r, v, rd);
        transact(0, 1'b0, 32'd3, 32'h0, r, v, rd);
        checks++;
        if (rd !== 32'h11) begin errors++; $display("FAIL abort_pre_value: got %h expected 11", rd); end
        @(posedge Clk); #1;
        drive(0, 1'b1, 1'b1, 32'd3, 32'h99);
        @(posedge Clk); #1;
        checks++;
        if (memWrite !== 1'b1) begin errors++; $display("FAIL abort_access_write: got %b expected 1", memWrite); end
        #1 Reset = 1'b0;
        #1;
        checks++;
        if (memWrite !== 1'b0) begin errors++; $display("FAIL abort_memwrite_drop: got %b expected 0", memWrite); end
        checks++;
        if (req0Ready !== 1'b0 || req0RData !== 32'h0) begin
            errors++; $display("FAIL abort_outputs_clear: got ready=%b rdata=%h expected 0/0", req0Ready, req0RData);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge Clk); #1;
        Reset = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            if (req0RValid || req1RValid) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen !== 1'b0) begin errors++; $display("FAIL abort_no_rvalid: got rvalid expected none"); end
        transact(0, 1'b0, 32'd3, 32'h0, r, v, rd);
        checks++;
        if (r !== 2) begin errors++; $display("FAIL abort_first_grant: got %0d expected 2", r); end
        checks++;
        if (rd !== 32'h11) begin errors++; $display("FAIL abort_addr3_intact: got %h expected 11", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_arbitration();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
